// File: rtl/krnl_partialknn_mem_pkg.sv
// rtl/krnl_partialknn_mem_pkg.sv - shared types and helpers for the banked partialKnn local buffer
package krnl_partialknn_mem_pkg;

    // Clear sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } clr_state_t;

    // Legal range of the read pipeline depth
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Address interleaving: low bits pick the bank, the rest pick the row
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned num_banks);
        return addr % num_banks;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned num_banks);
        return addr / num_banks;
    endfunction

endpackage

// File: rtl/krnl_partialknn_uram_bank.sv
// rtl/krnl_partialknn_uram_bank.sv - one simple-dual-port bank with byte-enable write and registered read
module krnl_partialknn_uram_bank #(
    parameter int DATA_WIDTH = 256,
    parameter int ROWS       = 512,
    parameter int ROW_WIDTH  = 9,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ROW_WIDTH-1:0]  wr_row,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ROW_WIDTH-1:0]  rd_row,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [ROWS];

    // Byte-masked write and registered read; the read returns the pre-write word on a row collision
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_en && wr_be[i]) mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
        end
        if (rd_en) rd_data <= mem[rd_row];
    end

endmodule

// File: rtl/krnl_partialknn_banked_uram_1r1w.sv
// rtl/krnl_partialknn_banked_uram_1r1w.sv - banked 1R1W local buffer with forwarding, range check and clear sequencer
module krnl_partialknn_banked_uram_1r1w
    import krnl_partialknn_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LATENCY = 3,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done
);

    localparam int BANK_BITS = clog2(NUM_BANKS);
    localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_W     = (clog2(ROWS) > 0) ? clog2(ROWS) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [2:0]          LAST_DRN = 3'(RD_LATENCY - 1);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("RD_LATENCY out of range");
    end

    clr_state_t       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [2:0]       drn_q, drn_d;
    logic             done_d;

    logic              rd_oor, wr_oor, req_ok, rd_accept, wr_accept, fwd_hit, clearing;
    logic [BSEL_W-1:0] rd_bank, wr_bank, s1_bank;
    logic [ROW_W-1:0]  rd_row, wr_row;
    logic [DATA_WIDTH-1:0] fwd_mask, s1_mask, s1_wdata, merged, last_word, hold_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [RD_LATENCY-1:0] vld_q, err_q;

    // Address decode, request qualification and same-address forwarding detect
    always_comb begin
        rd_oor    = {1'b0, rd_addr} >= DEPTH_V;
        wr_oor    = {1'b0, wr_addr} >= DEPTH_V;
        rd_bank   = BSEL_W'(bank_of(32'(rd_addr), NUM_BANKS));
        wr_bank   = BSEL_W'(bank_of(32'(wr_addr), NUM_BANKS));
        rd_row    = ROW_W'(row_of(32'(rd_addr), NUM_BANKS));
        wr_row    = ROW_W'(row_of(32'(wr_addr), NUM_BANKS));
        clearing  = (state_q == CLEAR);
        // clear_start wins over any request issued alongside it
        req_ok    = (state_q == IDLE) && !clear_start;
        rd_accept = rd_en && req_ok;
        wr_accept = wr_en && req_ok && !wr_oor && (|wr_be);
        fwd_hit   = rd_accept && !rd_oor && wr_accept && (wr_addr == rd_addr);
        fwd_mask  = '0;
        for (int i = 0; i < BE_WIDTH; i++) fwd_mask[8*i +: 8] = {8{wr_be[i]}};
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_we, bank_re;
        assign bank_we = clearing || (wr_accept && (wr_bank == BSEL_W'(b)));
        assign bank_re = rd_accept && !rd_oor && (rd_bank == BSEL_W'(b));

        krnl_partialknn_uram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROWS       (ROWS),
            .ROW_WIDTH  (ROW_W),
            .BE_WIDTH   (BE_WIDTH)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_we),
            .wr_row  (clearing ? row_q : wr_row),
            .wr_data (clearing ? '0 : wr_data),
            .wr_be   (clearing ? '1 : wr_be),
            .rd_en   (bank_re),
            .rd_row  (rd_row),
            .rd_data (bank_rdata[b])
        );
    end

    // Side information travelling with the array read: bank select and the write-first overlay
    always_ff @(posedge clk) begin
        s1_bank  <= rd_bank;
        s1_mask  <= fwd_hit ? fwd_mask : '0;
        s1_wdata <= wr_data;
    end

    // Stage-1 word: out-of-range reads return zero, otherwise overlay any same-cycle write bytes
    always_comb begin
        merged = '0;
        if (!err_q[0]) merged = (bank_rdata[s1_bank] & ~s1_mask) | (s1_wdata & s1_mask);
    end

    // Valid and error tracking for every stage of the read pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q[0] <= rd_accept;
            err_q[0] <= rd_oor;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign last_word = merged;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY-1];
        // Output pipeline stages after the array register
        always_ff @(posedge clk) begin
            pipe_q[0] <= merged;
            for (int k = 1; k < RD_LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
        end
        assign last_word = pipe_q[RD_LATENCY-2];
    end

    // Last delivered word, so rd_data holds between valid cycles and is zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     hold_q <= '0;
        else if (vld_q[RD_LATENCY-1])   hold_q <= last_word;
    end

    assign rd_valid   = vld_q[RD_LATENCY-1];
    assign rd_err     = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
    assign rd_data    = vld_q[RD_LATENCY-1] ? last_word : hold_q;
    assign clear_busy = (state_q != IDLE);

    // Clear sequencer state, row counter, drain counter and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            drn_q      <= '0;
            clear_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            drn_q      <= drn_d;
            clear_done <= done_d;
        end
    end

    // Clear sequencer next state: sweep every row, then let in-flight reads retire
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drn_d   = drn_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    row_d   = '0;
                end
            end
            CLEAR: begin
                row_d = row_q + 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = DRAIN;
                    row_d   = '0;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == LAST_DRN) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_krnl_partialknn_banked_uram_1r1w.sv
// tb/tb_krnl_partialknn_banked_uram_1r1w.sv - scoreboard bench for the banked 1R1W local buffer
module tb_krnl_partialknn_banked_uram_1r1w;

    localparam int DW    = 256;
    localparam int AW    = 12;
    localparam int DEPTH = 2048;
    localparam int NB    = 4;
    localparam int LAT   = 3;
    localparam int BEW   = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, rd_en, clear_start;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [BEW-1:0] wr_be;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_err, clear_busy, clear_done;

    always #5 clk = ~clk;

    krnl_partialknn_banked_uram_1r1w #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .NUM_BANKS  (NB),
        .RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_err      (rd_err),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            c;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [DEPTH];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            busy_cnt, done_cnt, bc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expectation
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 data %h required no read outstanding", rd_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", rd_data, mon_e.d);
                chk("rd_err", DW'(rd_err), DW'(mon_e.e));
                chk("rd_latency_cycle", DW'(cyc), DW'(mon_e.c));
            end
        end
    end

    // One request cycle; when track is set the model is updated and the expected read is queued
    task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input logic [BEW-1:0] wbe,
                         input bit re, input int ra, input bit cs, input bit track);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = AW'(ra); clear_start = cs;
        if (track) begin
            if (we && wa < DEPTH)
                for (int i = 0; i < BEW; i++) if (wbe[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
            if (re) begin
                e.d = (ra < DEPTH) ? model[ra] : '0;
                e.e = (ra >= DEPTH);
                e.c = cyc + LAT;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; clear_start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d reads outstanding required 0", sb.size());
        end
    endtask

    // Full clear; a read and write issued with clear_start and during busy must be ignored
    task automatic run_clear(output int busy, output int done);
        busy = 0;
        done = 0;
        drive(1, 5, pat(8'h99), '1, 1, 5, 1, 0);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (clear_busy) busy++;
            if (clear_done) done++;
            if (i == 10) begin rd_en = 1'b1; rd_addr = AW'(100); end
            if (i == 11) rd_en = 1'b0;
            if (i == 20) begin wr_en = 1'b1; wr_addr = AW'(7); wr_data = pat(8'h99); wr_be = '1; end
            if (i == 21) begin wr_en = 1'b0; wr_be = '0; end
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) @(negedge clk);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_rd_valid", DW'(rd_valid), '0);
        chk("reset_rd_err", DW'(rd_err), '0);
        chk("reset_clear_busy", DW'(clear_busy), '0);
        chk("reset_clear_done", DW'(clear_done), '0);
        reset = 1'b1;

        // Write then read the next cycle
        drive(1, 5, pat(8'hA5), '1, 0, 0, 0, 1);
        drive(0, 0, '0, '0, 1, 5, 0, 1);
        wait_drain();
        @(negedge clk);
        chk("hold_rd_valid", DW'(rd_valid), '0);
        chk("hold_rd_data", rd_data, pat(8'hA5));

        // Same-cycle partial write and read: write-first merge, then committed value
        drive(1, 9, pat(8'h11), '1, 0, 0, 0, 1);
        drive(1, 9, pat(8'hFF), 32'h0000_000F, 1, 9, 0, 1);
        drive(0, 0, '0, '0, 1, 9, 0, 1);
        wait_drain();
        chk("merge_model", model[9], {{28{8'h11}}, 32'hFFFF_FFFF});

        // Fill 0..7 across all banks, then back-to-back reads
        for (int a = 0; a < 8; a++) drive(1, a, pat(8'(8'h30 + a)), '1, 0, 0, 0, 1);
        for (int a = 0; a < 8; a++) drive(0, 0, '0, '0, 1, a, 0, 1);
        // Same bank, different rows, same cycle; zero byte-enable is no write
        drive(1, 12, pat(8'hC3), '1, 1, 8, 0, 1);
        drive(1, 6, pat(8'hEE), '0, 1, 12, 0, 1);
        drive(0, 0, '0, '0, 1, 6, 0, 1);
        wait_drain();

        // Out-of-range reads and a dropped out-of-range write aliasing row 238 of bank 0
        drive(1, 952, pat(8'h77), '1, 0, 0, 0, 1);
        drive(0, 0, '0, '0, 1, 3000, 0, 1);
        drive(1, 3000, pat(8'hDE), '1, 0, 0, 0, 1);
        drive(0, 0, '0, '0, 1, 952, 0, 1);
        drive(0, 0, '0, '0, 1, 4095, 0, 1);
        wait_drain();

        // Read accepted just before clear_start still retires with old data
        drive(0, 0, '0, '0, 1, 5, 0, 1);
        run_clear(busy_cnt, done_cnt);
        chk("clear_busy_cycles", DW'(busy_cnt), DW'(DEPTH / NB + LAT));
        chk("clear_done_pulses", DW'(done_cnt), DW'(1));
        for (int a = 0; a < DEPTH; a++) drive(0, 0, '0, '0, 1, a, 0, 1);
        wait_drain();

        // Reset in the middle of a clear
        drive(1, 7, pat(8'h3C), '1, 0, 0, 0, 1);
        drive(0, 0, '0, '0, 1, 7, 0, 1);
        wait_drain();
        drive(0, 0, '0, '0, 0, 0, 1, 0);
        bc = 0;
        for (int i = 0; i < 300 && bc < 200; i++) begin
            @(negedge clk);
            if (clear_busy) bc++;
        end
        chk("abort_reached_row200", DW'(bc), DW'(200));
        #2 reset = 1'b0;
        #1;
        chk("abort_clear_busy", DW'(clear_busy), '0);
        chk("abort_rd_data", rd_data, '0);
        chk("abort_rd_valid", DW'(rd_valid), '0);
        chk("abort_clear_done", DW'(clear_done), '0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", DW'(clear_done), '0);
        reset = 1'b1;
        run_clear(busy_cnt, done_cnt);
        chk("restart_busy_cycles", DW'(busy_cnt), DW'(DEPTH / NB + LAT));
        chk("restart_done_pulses", DW'(done_cnt), DW'(1));
        drive(0, 0, '0, '0, 1, 7, 0, 1);
        drive(0, 0, '0, '0, 1, 0, 0, 1);
        drive(0, 0, '0, '0, 1, 2047, 0, 1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/krnl_partialknn_banked_uram_1r1w.md
Name: krnl_partialknn_banked_uram_1r1w

Overview:
Parametrised successor to the single-port URAM local-buffer wrappers used by the partialKnn kernels. It provides one independent read port and one independent write port that are usable in the same cycle. Storage is split into NUM_BANKS address-interleaved banks. The block adds byte-enable writes, same-address write-to-read forwarding, a configurable read pipeline with valid tracking, out-of-range detection, and a hardware clear sequencer. It sits between the kernel compute pipeline and its per-PE local distance/index buffers.

Parameters:
DATA_WIDTH, 256, word width in bits; must be a multiple of 8
DEPTH, 2048, total words; must be a multiple of NUM_BANKS
ADDR_WIDTH, 11, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
NUM_BANKS, 4, power of 2, from 1 to 8; bank = addr[log2(NUM_BANKS)-1:0]
RD_LATENCY, 3, read latency in cycles (1..4); stage 1 is the array register, later stages are the output pipeline
BE_WIDTH, DATA_WIDTH/8, width of the byte-enable bus (derived)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  DATA_WIDTH  write data
wr_be  in  BE_WIDTH  byte enables; bit i covers data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read word address
rd_data  out  DATA_WIDTH  read data, qualified by rd_valid
rd_valid  out  1  rd_data is valid this cycle
rd_err  out  1  high together with rd_valid when the read address was out of range
clear_start  in  1  one-cycle pulse that starts zeroing the whole memory
clear_busy  out  1  clear sequence in progress
clear_done  out  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (reset=0, asynchronous): rd_data=0, rd_valid=0, rd_err=0, clear_busy=0, clear_done=0, read pipeline valid bits cleared, FSM goes to IDLE. Array contents are not reset.
- Read: rd_en accepted at cycle t gives rd_valid=1 and rd_data at t+RD_LATENCY.
  - Fully pipelined: one read per cycle, no stalls.
  - rd_data holds its last value while rd_valid=0.
- Write: commits at the clock edge ending cycle t. Only bytes with wr_be=1 are updated. wr_be=0 means no write.
- Read-after-write: a read issued at t+1 to the same address returns the new data.
- Same-cycle read and write to the same address: write-first. The returned word is the old word with the enabled bytes replaced by wr_data. This merge is captured at issue and carried down the pipeline.
- Out of range (addr >= DEPTH):
  - Write: dropped.
  - Read: still produces rd_valid at the normal latency, with rd_data=0 and rd_err=1.
- Bank mapping: bank = low address bits; row = addr >> log2(NUM_BANKS). The read port and write port may hit any banks, including the same bank.
- Clear FSM:
  - IDLE: on clear_start -> CLEAR with row counter = 0, clear_busy=1.
  - CLEAR: each cycle writes 0 to the current row in all banks and increments the row counter. After row DEPTH/NUM_BANKS-1 -> DRAIN.
  - DRAIN: waits RD_LATENCY cycles so in-flight reads retire, then -> IDLE with clear_done=1 for one cycle and clear_busy=0.
  - Total busy cycles = DEPTH/NUM_BANKS + RD_LATENCY.
- Requests during clear_busy=1:
  - wr_en and rd_en are ignored.
  - Ignored reads never produce rd_valid.
  - Reads accepted before clear_start still retire normally.
- clear_start while busy: ignored.
- clear_start in the same cycle as wr_en/rd_en: the request is ignored, and clear takes priority.
- Reset during clear: FSM returns to IDLE and no clear_done is issued. Memory is left partially cleared, with undefined contents in uncleared rows.

Decomposition:
- Shared package krnl_partialknn_mem_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR, DRAIN)
  - functions clog2 and bank_of/row_of
  - the RD_LATENCY range-check constants
- One sub-module, krnl_partialknn_uram_bank: a single simple-dual-port bank.
  - Write side: byte-enable write.
  - Read side: registered output, no reset on data, inferred as URAM.
  - Instantiated NUM_BANKS times.
- The top level contains the bank decode, forwarding merge, read pipeline/valid shift register, and clear FSM.

Test Plan:
- Write 0xA5..A5 to addr 5 with wr_be all ones; read addr 5 at the next cycle -> rd_valid exactly 3 cycles later with rd_data=0xA5..A5 and rd_err=0.
- Write addr 9 = 0x11..11. Then, in one cycle, write addr 9 = 0xFF..FF with wr_be=0x0000_000F and read addr 9 -> low 4 bytes are 0xFF and the rest are 0x11.
- Back-to-back reads of addrs 0..7 spanning all 4 banks after a known fill -> 8 consecutive rd_valid cycles, in order, with correct data.
- Read addr 3000 with DEPTH=2048 and ADDR_WIDTH=12 -> rd_valid=1, rd_err=1, rd_data=0. Write to addr 3000 leaves addrs 952 and 3000-2048 unchanged.
- clear_start after filling memory -> clear_busy high for 512+3 cycles, then clear_done pulses once. A read of addr 100 issued during busy gets no rd_valid. Reads of every address afterward return 0.
- Assert reset mid-CLEAR at row 200 -> outputs 0 immediately (asynchronously). After release, clear_start restarts the sequence from row 0 with full busy length.
